input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage directly upstream of the SoC top; feeds its `buttons_i` and `sw_i` inputs.
- Takes raw, asynchronous board buttons and switches.
- Synchronises them into the `clk` domain with a 2-flop chain, then debounces them.
- Outputs clean levels, plus one-cycle press/release/change pulses that MEMORY-mapped IO can consume.

Parameters:
- N_BTN, 4, number of push buttons.
- N_SW, 12, number of slide switches.
- DEBOUNCE_CYCLES, 1000000, required stable cycles before a level is accepted (10 ms at 100 MHz); legal range ≥ 2.
- CNT_W, 20, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- btn_raw_i  in  N_BTN  raw button pins, asynchronous.
- sw_raw_i  in  N_SW  raw switch pins, asynchronous.
- btn_o  out  N_BTN  debounced button levels (drives top `buttons_i`).
- btn_press_o  out  N_BTN  one-cycle pulse per bit on debounced 0→1.
- btn_release_o  out  N_BTN  one-cycle pulse per bit on debounced 1→0.
- sw_o  out  N_SW  debounced switch vector (drives top `sw_i`).
- sw_changed_o  out  1  one-cycle pulse when sw_o updates.

Behaviour:
- All state is registered; no combinational path from any input to any output.
- Reset (rst=1 at a rising edge):
  - Sync flops, counters and sw_last are cleared.
  - btn_o, sw_o, btn_press_o, btn_release_o and sw_changed_o are all 0.
  - Reset asserted mid-count discards the partial count.
- Synchroniser: s1 <= raw; s2 <= s1, per bit, for both buttons and switches.
- Button debounce: one independent CNT_W counter per bit.
  - s2[i] == btn_o[i]: cnt[i] <= 0.
  - s2[i] != btn_o[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != btn_o[i] and cnt[i] == DEBOUNCE_CYCLES-1: btn_o[i] <= s2[i] and cnt[i] <= 0. In the same edge, btn_press_o[i] <= s2[i] and btn_release_o[i] <= ~s2[i].
  - Otherwise both pulses are 0 the next cycle.
- Button latency: raw changes before edge k and stays stable → btn_o and the pulse update at edge k+DEBOUNCE_CYCLES+1.
- Glitch rejection: any return of s2 to btn_o before acceptance clears the counter. A bounce shorter than DEBOUNCE_CYCLES cycles never reaches btn_o.
- Buttons are fully independent; simultaneous events on several bits produce simultaneous pulses.
- Switch debounce: one shared counter for the whole vector, plus register sw_last <= s2 (switch part) every cycle.
  - s2 != sw_last (vector moved): cnt_sw <= 0.
  - Else if s2 == sw_o: cnt_sw <= 0.
  - Else if cnt_sw < DEBOUNCE_CYCLES-1: cnt_sw <= cnt_sw+1.
  - Else: sw_o <= s2, cnt_sw <= 0, sw_changed_o <= 1 for one cycle.
- Switch latency: all bits settled before edge k → sw_o updates at edge k+DEBOUNCE_CYCLES+2. Any further bit movement restarts the count.
- Counters never wrap: they saturate at DEBOUNCE_CYCLES-1 only transiently, then clear.
- Inputs held high through reset release are treated as new changes. Their outputs rise after the normal latency, with the press/change pulse.

Test Plan:
- DEBOUNCE_CYCLES=4, rst held 3 cycles → all outputs 0. Then btn_raw_i=4'b0001 set before edge 0 → btn_o=4'b0001 and btn_press_o=4'b0001 after edge 5; btn_press_o is 0 after edge 6.
- DEBOUNCE_CYCLES=4, btn_raw_i[1] pulses high for 3 cycles, low 2, high 3, then low → btn_o[1] stays 0 and btn_press_o never asserts.
- DEBOUNCE_CYCLES=4, btn_o=4'b0011 stable; raw → 4'b0000 before edge 10 → btn_o=0 after edge 15; btn_release_o=4'b0011 for exactly one cycle.
- DEBOUNCE_CYCLES=4, sw_raw_i=12'hA5C before edge 0 → sw_o=12'hA5C and sw_changed_o=1 after edge 6 only. Then bit 0 toggles every 2 cycles for 20 cycles → sw_o unchanged and no pulse.
- DEBOUNCE_CYCLES=4, btn_raw_i=4'b1000 held; rst pulses 1 cycle at edge 3 mid-count → btn_o stays 0 until after edge 3+4+2=9 (the same latency rule applied from reset release), then single press pulse.
- DEBOUNCE_CYCLES=4, all 4 buttons and 12 switches change simultaneously → btn_press_o=4'hF at edge 5 and sw_changed_o at edge 6, each exactly one cycle.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Board-side bundle for input_conditioner: raw pins in, clean levels and edge pulses out.
// The conditioner takes the slave modport; the consumer or bench takes the master modport.
interface input_conditioner_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 12
);
    logic [N_BTN-1:0] btn_raw_i;
    logic [N_SW-1:0]  sw_raw_i;
    logic [N_BTN-1:0] btn_o;
    logic [N_BTN-1:0] btn_press_o;
    logic [N_BTN-1:0] btn_release_o;
    logic [N_SW-1:0]  sw_o;
    logic             sw_changed_o;

    modport slave (
        input  btn_raw_i,
        input  sw_raw_i,
        output btn_o,
        output btn_press_o,
        output btn_release_o,
        output sw_o,
        output sw_changed_o
    );

    modport master (
        output btn_raw_i,
        output sw_raw_i,
        input  btn_o,
        input  btn_press_o,
        input  btn_release_o,
        input  sw_o,
        input  sw_changed_o
    );
endinterface

// File: rtl/input_conditioner.sv
// Two-flop synchroniser plus debounce for board buttons (one counter per bit) and
// switches (one shared counter), with registered level outputs and one-cycle pulses.
module input_conditioner #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 12,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    input_conditioner_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_BTN-1:0] btn_s1_r, btn_s2_r, btn_r, press_r, release_r;
    logic [N_SW-1:0]  sw_s1_r, sw_s2_r, sw_last_r, sw_r;
    logic             sw_chg_r;
    logic [CNT_W-1:0] btn_cnt_r [N_BTN];
    logic [CNT_W-1:0] sw_cnt_r;

    logic [N_BTN-1:0] btn_nxt_s, press_nxt_s, release_nxt_s;
    logic [CNT_W-1:0] btn_cnt_nxt_s [N_BTN];
    logic [N_SW-1:0]  sw_nxt_s;
    logic             sw_chg_nxt_s;
    logic [CNT_W-1:0] sw_cnt_nxt_s;

    // Per-bit button debounce: count while synced input differs, accept at the limit.
    always_comb begin
        btn_nxt_s     = btn_r;
        press_nxt_s   = {N_BTN{1'b0}};
        release_nxt_s = {N_BTN{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            btn_cnt_nxt_s[i] = CNT_ZERO;
            if (btn_s2_r[i] == btn_r[i]) begin
                btn_cnt_nxt_s[i] = CNT_ZERO;
            end else if (btn_cnt_r[i] < CNT_MAX) begin
                btn_cnt_nxt_s[i] = btn_cnt_r[i] + CNT_ONE;
            end else begin
                btn_nxt_s[i]     = btn_s2_r[i];
                press_nxt_s[i]   = btn_s2_r[i];
                release_nxt_s[i] = ~btn_s2_r[i];
            end
        end
    end

    // Switch vector debounce: any movement between samples restarts the shared count.
    always_comb begin
        sw_nxt_s     = sw_r;
        sw_chg_nxt_s = 1'b0;
        sw_cnt_nxt_s = CNT_ZERO;
        if (sw_s2_r != sw_last_r) begin
            sw_cnt_nxt_s = CNT_ZERO;
        end else if (sw_s2_r == sw_r) begin
            sw_cnt_nxt_s = CNT_ZERO;
        end else if (sw_cnt_r < CNT_MAX) begin
            sw_cnt_nxt_s = sw_cnt_r + CNT_ONE;
        end else begin
            sw_nxt_s     = sw_s2_r;
            sw_chg_nxt_s = 1'b1;
        end
    end

    // State registers: synchroniser chain, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_r  <= {N_BTN{1'b0}};
            btn_s2_r  <= {N_BTN{1'b0}};
            btn_r     <= {N_BTN{1'b0}};
            press_r   <= {N_BTN{1'b0}};
            release_r <= {N_BTN{1'b0}};
            sw_s1_r   <= {N_SW{1'b0}};
            sw_s2_r   <= {N_SW{1'b0}};
            sw_last_r <= {N_SW{1'b0}};
            sw_r      <= {N_SW{1'b0}};
            sw_chg_r  <= 1'b0;
            sw_cnt_r  <= CNT_ZERO;
            for (int i = 0; i < N_BTN; i++) begin
                btn_cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            btn_s1_r  <= bus.btn_raw_i;
            btn_s2_r  <= btn_s1_r;
            btn_r     <= btn_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            sw_s1_r   <= bus.sw_raw_i;
            sw_s2_r   <= sw_s1_r;
            sw_last_r <= sw_s2_r;
            sw_r      <= sw_nxt_s;
            sw_chg_r  <= sw_chg_nxt_s;
            sw_cnt_r  <= sw_cnt_nxt_s;
            for (int i = 0; i < N_BTN; i++) begin
                btn_cnt_r[i] <= btn_cnt_nxt_s[i];
            end
        end
    end

    assign bus.btn_o         = btn_r;
    assign bus.btn_press_o   = press_r;
    assign bus.btn_release_o = release_r;
    assign bus.sw_o          = sw_r;
    assign bus.sw_changed_o  = sw_chg_r;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4: stimulus queues the
// expected pulse events, a negedge monitor pops and compares whenever a pulse appears.
module tb_input_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          at;
        logic [3:0]  btn;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [11:0] sw;
        logic        chg;
    } ev_t;
    ev_t q[$];

    input_conditioner_if #(.N_BTN(4), .N_SW(12)) bus ();

    input_conditioner #(
        .N_BTN(4), .N_SW(12), .DEBOUNCE_CYCLES(4), .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic [3:0] btn, input logic [3:0] press,
                        input logic [3:0] rel, input logic [11:0] sw, input logic chg);
        ev_t e;
        e.at = at; e.btn = btn; e.press = press; e.rel = rel; e.sw = sw; e.chg = chg;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: flag missed events, then compare any presented pulse.
    always @(negedge clk) begin
        ev_t e;
        if (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event: expected pulse at cycle %0d not seen (now %0d)", e.at, cyc);
        end
        if ((|bus.btn_press_o) || (|bus.btn_release_o) || bus.sw_changed_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cycle %0d press=%h release=%h chg=%b, no event expected",
                         cyc, bus.btn_press_o, bus.btn_release_o, bus.sw_changed_o);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || e.btn !== bus.btn_o || e.press !== bus.btn_press_o ||
                    e.rel !== bus.btn_release_o || e.sw !== bus.sw_o || e.chg !== bus.sw_changed_o) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d btn=%h press=%h rel=%h sw=%h chg=%b expected cyc=%0d btn=%h press=%h rel=%h sw=%h chg=%b",
                             cyc, bus.btn_o, bus.btn_press_o, bus.btn_release_o, bus.sw_o, bus.sw_changed_o,
                             e.at, e.btn, e.press, e.rel, e.sw, e.chg);
                end
            end
        end
    end

    initial begin
        int base;
        bus.btn_raw_i = 4'b0000;
        bus.sw_raw_i  = 12'h000;

        // Reset held three cycles: everything low.
        repeat (3) @(negedge clk);
        chk("reset_btn",     {28'd0, bus.btn_o}, 32'd0);
        chk("reset_press",   {28'd0, bus.btn_press_o}, 32'd0);
        chk("reset_release", {28'd0, bus.btn_release_o}, 32'd0);
        chk("reset_sw",      {20'd0, bus.sw_o}, 32'd0);
        chk("reset_chg",     {31'd0, bus.sw_changed_o}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single press on bit 0: accepted at edge 5.
        bus.btn_raw_i = 4'b0001;
        base = cyc + 1;
        push(base + 5, 4'b0001, 4'b0001, 4'b0000, 12'h000, 1'b0);
        repeat (10) @(negedge clk);

        // Bounce on bit 1 shorter than the debounce window.
        bus.btn_raw_i = 4'b0011; repeat (3) @(negedge clk);
        bus.btn_raw_i = 4'b0001; repeat (2) @(negedge clk);
        bus.btn_raw_i = 4'b0011; repeat (3) @(negedge clk);
        bus.btn_raw_i = 4'b0001; repeat (10) @(negedge clk);
        chk("glitch_btn", {28'd0, bus.btn_o}, 32'h1);

        // Settle bits 0 and 1 high, then release both together.
        bus.btn_raw_i = 4'b0011;
        base = cyc + 1;
        push(base + 5, 4'b0011, 4'b0010, 4'b0000, 12'h000, 1'b0);
        repeat (10) @(negedge clk);
        chk("btn_0011", {28'd0, bus.btn_o}, 32'h3);
        bus.btn_raw_i = 4'b0000;
        base = cyc + 1;
        push(base + 5, 4'b0000, 4'b0000, 4'b0011, 12'h000, 1'b0);
        repeat (10) @(negedge clk);

        // Switch vector accepted at edge 6, then bit 0 chatter must be ignored.
        bus.sw_raw_i = 12'hA5C;
        base = cyc + 1;
        push(base + 6, 4'b0000, 4'b0000, 4'b0000, 12'hA5C, 1'b1);
        repeat (10) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            bus.sw_raw_i[0] = ~bus.sw_raw_i[0];
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("sw_chatter", {20'd0, bus.sw_o}, 32'hA5C);

        // Reset at edge 3 mid-count: button restarts, switches are re-accepted.
        bus.btn_raw_i = 4'b1000;
        base = cyc + 1;
        push(base + 9,  4'b1000, 4'b1000, 4'b0000, 12'h000, 1'b0);
        push(base + 10, 4'b1000, 4'b0000, 4'b0000, 12'hA5C, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_btn", {28'd0, bus.btn_o}, 32'd0);
        chk("midreset_sw",  {20'd0, bus.sw_o}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_hold", {28'd0, bus.btn_o}, 32'd0);
        repeat (10) @(negedge clk);

        bus.btn_raw_i = 4'b0000;
        base = cyc + 1;
        push(base + 5, 4'b0000, 4'b0000, 4'b1000, 12'hA5C, 1'b0);
        repeat (10) @(negedge clk);

        // Everything changes together.
        bus.btn_raw_i = 4'b1111;
        bus.sw_raw_i  = 12'h5A3;
        base = cyc + 1;
        push(base + 5, 4'b1111, 4'b1111, 4'b0000, 12'hA5C, 1'b0);
        push(base + 6, 4'b1111, 4'b0000, 4'b0000, 12'h5A3, 1'b1);
        repeat (12) @(negedge clk);
        chk("all_btn", {28'd0, bus.btn_o}, 32'hF);
        chk("all_sw",  {20'd0, bus.sw_o}, 32'h5A3);
        chk("queue_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
